// File: rtl/dma_burst_master_if.sv
// dma_burst_master_if: split-transaction bus between the DMA burst master and its arbiter/slave.
interface dma_burst_master_if;
  logic        request_bus;
  logic        bus_grant;
  logic        begin_transaction_out;
  logic [31:0] address_data_out;
  logic [7:0]  burst_size_out;
  logic        read_n_write_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic [31:0] address_data_in;
  logic        data_valid_in;
  logic        end_transaction_in;
  logic        busy_in;
  logic        error_in;
  modport master (
    output request_bus, begin_transaction_out, address_data_out, burst_size_out,
           read_n_write_out, data_valid_out, end_transaction_out,
    input  bus_grant, address_data_in, data_valid_in, end_transaction_in, busy_in, error_in
  );
  modport slave (
    input  request_bus, begin_transaction_out, address_data_out, burst_size_out,
           read_n_write_out, data_valid_out, end_transaction_out,
    output bus_grant, address_data_in, data_valid_in, end_transaction_in, busy_in, error_in
  );
endinterface

// File: rtl/dma_burst_master.sv
// dma_burst_master: moves a block of words between a local 512-word memory and the bus in bursts.
module dma_burst_master #(
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               to_bus,
  input  logic [31:0]        bus_start_address,
  input  logic [8:0]         mem_start_address,
  input  logic [9:0]         block_size,
  input  logic [7:0]         burst_size,
  output logic               busy,
  output logic               done,
  output logic               error,
  dma_burst_master_if.master bus,
  output logic [8:0]         mem_address,
  output logic               mem_write_enable,
  output logic [31:0]        mem_write_data,
  input  logic [31:0]        mem_read_data
);
  typedef enum logic [2:0] {IDLE, REQUEST, BEGIN, READ_DATA, WRITE_FETCH, WRITE_DATA, WRITE_END, NEXT} state_t;
  state_t      state;
  logic        dir;
  logic [31:0] bus_addr;
  logic [8:0]  mem_addr;
  logic [9:0]  remaining;
  logic [7:0]  burst_max;
  logic [8:0]  len;
  logic [8:0]  beats;
  logic        fresh;
  logic [31:0] out_r;
  logic [9:0]  span;
  logic [8:0]  len_next;
  assign span = {2'b0, burst_max} + 10'd1;
  assign len_next = span < remaining ? span[8:0] : remaining[8:0];
  // A word's first cycle comes straight from memory; stalled cycles replay the captured copy
  assign bus.address_data_out = fresh ? mem_read_data : out_r;
  always_ff @(posedge clock) begin
    if (reset || (state != IDLE && bus.error_in)) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= !reset;
      bus.request_bus <= 1'b0;
      bus.begin_transaction_out <= 1'b0;
      bus.burst_size_out <= '0;
      bus.read_n_write_out <= 1'b0;
      bus.data_valid_out <= 1'b0;
      bus.end_transaction_out <= 1'b0;
      out_r <= '0;
      fresh <= 1'b0;
      mem_address <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data <= '0;
    end else begin
      done <= 1'b0;
      bus.begin_transaction_out <= 1'b0;
      bus.burst_size_out <= '0;
      bus.read_n_write_out <= 1'b0;
      bus.end_transaction_out <= 1'b0;
      mem_write_enable <= 1'b0;
      case (state)
        IDLE: if (start) begin
          error <= 1'b0;
          dir <= to_bus;
          bus_addr <= bus_start_address;
          mem_addr <= mem_start_address;
          remaining <= block_size;
          burst_max <= burst_size;
          done <= block_size == '0;
          busy <= block_size != '0;
          bus.request_bus <= block_size != '0;
          state <= block_size == '0 ? IDLE : REQUEST;
        end
        REQUEST: if (bus.bus_grant) begin
          state <= BEGIN;
          bus.begin_transaction_out <= 1'b1;
          bus.burst_size_out <= 8'(len_next - 9'd1);
          bus.read_n_write_out <= !dir;
          out_r <= bus_addr;
          len <= len_next;
          beats <= '0;
        end
        BEGIN: begin
          out_r <= '0;
          mem_address <= mem_addr;
          state <= dir ? WRITE_FETCH : READ_DATA;
        end
        READ_DATA: begin
          if (bus.data_valid_in && beats != len) begin
            mem_write_enable <= 1'b1;
            mem_address <= mem_addr;
            mem_write_data <= bus.address_data_in;
            mem_addr <= mem_addr + 9'd1;
            remaining <= remaining - 10'd1;
            beats <= beats + 9'd1;
          end
          if (bus.end_transaction_in) begin
            state <= NEXT;
            bus.request_bus <= 1'b0;
          end
        end
        WRITE_FETCH: begin
          state <= WRITE_DATA;
          bus.data_valid_out <= 1'b1;
          fresh <= 1'b1;
          mem_address <= mem_addr + 9'd1;
        end
        WRITE_DATA: if (!bus.busy_in) begin
          beats <= beats + 9'd1;
          remaining <= remaining - 10'd1;
          mem_addr <= mem_addr + 9'd1;
          // Memory already holds the following word, so fetch two ahead to keep words back-to-back
          mem_address <= mem_addr + 9'd2;
          fresh <= beats + 9'd1 != len;
          bus.data_valid_out <= beats + 9'd1 != len;
          bus.end_transaction_out <= beats + 9'd1 == len;
          out_r <= '0;
          state <= beats + 9'd1 == len ? WRITE_END : WRITE_DATA;
        end else begin
          fresh <= 1'b0;
          out_r <= bus.address_data_out;
        end
        WRITE_END: begin
          state <= NEXT;
          bus.request_bus <= 1'b0;
        end
        NEXT: begin
          bus_addr <= bus_addr + 32'(len) * ADDR_STEP;
          bus.request_bus <= remaining != '0;
          busy <= remaining != '0;
          done <= remaining == '0;
          state <= remaining != '0 ? REQUEST : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_burst_master.sv
// tb_dma_burst_master: table-driven transfers against a bus-slave/memory model, plus reset corner cases.
module tb_dma_burst_master;
  logic        clock, reset, start, to_bus;
  logic [31:0] bus_start_address;
  logic [8:0]  mem_start_address;
  logic [9:0]  block_size;
  logic [7:0]  burst_size;
  logic        busy, done, error;
  logic [8:0]  mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data, mem_read_data;
  logic        mem_clear;
  logic [31:0] mem [512];
  logic [40:0] wlog [$];
  int n_chk = 0, n_fail = 0;

  dma_burst_master_if bus();

  dma_burst_master #(.ADDR_STEP(4)) dut (
    .clock(clock), .reset(reset), .start(start), .to_bus(to_bus),
    .bus_start_address(bus_start_address), .mem_start_address(mem_start_address),
    .block_size(block_size), .burst_size(burst_size),
    .busy(busy), .done(done), .error(error), .bus(bus.master),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (mem_clear) for (int i = 0; i < 512; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    else if (mem_write_enable) mem[mem_address] <= mem_write_data;
    mem_read_data <= mem[mem_address];
  end

  always @(negedge clock) if (mem_write_enable) wlog.push_back({mem_address, mem_write_data});

  typedef struct {
    logic to_bus; logic [31:0] bus_addr; logic [8:0] mem_start; logic [9:0] block; logic [7:0] burst;
    int stall_word; int stall_cycles; int extra; int grant_wait; int err_burst; logic restart;
    int exp_bursts; logic [7:0] exp_bs_first; logic [7:0] exp_bs_last; logic [31:0] exp_last_addr;
    int exp_words; logic exp_rnw; int exp_done; logic exp_err; logic exp_req;
  } vec_t;
  vec_t vt [8];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic run_vec(input int k, input vec_t v);
    int bursts = 0, derr = 0, unstable = 0, dones = 0, reqs = 0, words = 0;
    int wait_cnt = 0, rd_left = 0, rd_extra = 0, rd_word = 0, stall_done = 0, acc = 0;
    logic [7:0] bs_first = 0, bs_last = 0;
    logic [31:0] last_addr = 0, held = 0;
    logic rnw = 0, holding = 0, err_fired = 0, finished = 0;
    string p = $sformatf("v%0d_", k);
    wlog.delete();
    mem_clear = 1;
    @(negedge clock);
    mem_clear = 0;
    to_bus = v.to_bus; bus_start_address = v.bus_addr; mem_start_address = v.mem_start;
    block_size = v.block; burst_size = v.burst; start = 1;
    @(negedge clock);
    start = 0; to_bus = !v.to_bus; bus_start_address = 32'hDEAD_BEEF;
    mem_start_address = 9'h155; block_size = 10'h3FF; burst_size = 8'h0F;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      bus.data_valid_in = 0; bus.end_transaction_in = 0; bus.error_in = 0;
      bus.busy_in = 0; bus.bus_grant = 0; start = 0;
      if (bus.request_bus) reqs++;
      if (done) dones++;
      if (err_fired) begin
        chk({p, "err_request_bus"}, 32'(bus.request_bus), 0);
        chk({p, "err_flag"}, 32'(error), 1);
        chk({p, "err_busy"}, 32'(busy), 0);
        chk({p, "err_data_valid"}, 32'(bus.data_valid_out), 0);
        finished = 1;
      end else if (done) finished = 1;
      else begin
        if (bus.request_bus) begin
          bus.bus_grant = wait_cnt >= v.grant_wait;
          wait_cnt++;
        end else wait_cnt = 0;
        if (bus.begin_transaction_out) begin
          bursts++;
          if (bursts == 1) begin
            bs_first = bus.burst_size_out;
            rnw = bus.read_n_write_out;
          end
          bs_last = bus.burst_size_out;
          last_addr = bus.address_data_out;
          if (v.err_burst == bursts) begin
            bus.error_in = 1;
            err_fired = 1;
          end else if (!v.to_bus) begin
            rd_left = int'(bus.burst_size_out) + 1;
            rd_extra = v.extra;
          end
          if (v.restart && bursts == 1) begin
            start = 1; block_size = 0; burst_size = 8'h00;
          end
        end else if (rd_left + rd_extra > 0) begin
          bus.data_valid_in = 1;
          if (rd_left > 0) begin
            bus.address_data_in = 32'hD000_0000 + 32'(rd_word);
            rd_word++; rd_left--;
          end else begin
            bus.address_data_in = 32'hBAD0_0000;
            rd_extra--;
          end
          bus.end_transaction_in = rd_left + rd_extra == 0;
        end
        if (bus.data_valid_out) begin
          if (holding && bus.address_data_out !== held) unstable++;
          if (acc == v.stall_word && stall_done < v.stall_cycles) begin
            bus.busy_in = 1; stall_done++; held = bus.address_data_out; holding = 1;
          end else begin
            holding = 0;
            if (bus.address_data_out !== 32'hA000_0000 + 32'(9'(v.mem_start + 9'(acc)))) derr++;
            acc++;
          end
        end
      end
      if (!finished) @(negedge clock);
    end
    bus.bus_grant = 0; bus.busy_in = 0; bus.error_in = 0;
    words = v.to_bus ? acc : wlog.size();
    if (v.to_bus && wlog.size() != 0) derr++;
    if (!v.to_bus) foreach (wlog[i]) if (wlog[i] !== {9'(v.mem_start + 9'(i)), 32'hD000_0000 + 32'(i)}) derr++;
    chk({p, "completed"}, 32'(finished), 1);
    chk({p, "bursts"}, bursts, v.exp_bursts);
    chk({p, "burst_size_first"}, 32'(bs_first), 32'(v.exp_bs_first));
    chk({p, "burst_size_last"}, 32'(bs_last), 32'(v.exp_bs_last));
    chk({p, "last_burst_addr"}, last_addr, v.exp_last_addr);
    chk({p, "words"}, words, v.exp_words);
    chk({p, "data_errors"}, derr, 0);
    chk({p, "unstable_cycles"}, unstable, 0);
    chk({p, "read_n_write"}, 32'(rnw), 32'(v.exp_rnw));
    chk({p, "done_count"}, dones, v.exp_done);
    chk({p, "error_flag"}, 32'(error), 32'(v.exp_err));
    chk({p, "request_seen"}, 32'(reqs > 0), 32'(v.exp_req));
    @(negedge clock);
    chk({p, "done_pulse_width"}, 32'(done), 0);
  endtask

  initial begin
    logic seen;
    reset = 1; start = 0; to_bus = 0; bus_start_address = 0; mem_start_address = 0;
    block_size = 0; burst_size = 0; mem_clear = 1;
    bus.bus_grant = 0; bus.address_data_in = 0; bus.data_valid_in = 0;
    bus.end_transaction_in = 0; bus.busy_in = 0; bus.error_in = 0;
    vt[0] = '{0, 32'h1000_0000, 9'h1FF, 10'd4, 8'd1,   -1, 0, 0, 0, 0, 0, 2, 8'd1, 8'd1, 32'h1000_0008, 4, 1, 1, 0, 1};
    vt[1] = '{1, 32'h2000_0000, 9'h010, 10'd3, 8'd7,    1, 2, 0, 0, 0, 1, 1, 8'd2, 8'd2, 32'h2000_0000, 3, 0, 1, 0, 1};
    vt[2] = '{0, 32'hFFFF_FFF8, 9'h100, 10'd5, 8'd2,   -1, 0, 2, 1, 0, 0, 2, 8'd2, 8'd1, 32'h0000_0004, 5, 1, 1, 0, 1};
    vt[3] = '{1, 32'h3000_0000, 9'h1FE, 10'd7, 8'd2,    3, 1, 0, 2, 0, 0, 3, 8'd2, 8'd0, 32'h3000_0018, 7, 0, 1, 0, 1};
    vt[4] = '{1, 32'h4000_0100, 9'h005, 10'd2, 8'd0,   -1, 0, 0, 0, 0, 0, 2, 8'd0, 8'd0, 32'h4000_0104, 2, 0, 1, 0, 1};
    vt[5] = '{0, 32'h5000_0000, 9'h0AA, 10'd1, 8'd255, -1, 0, 0, 0, 0, 0, 1, 8'd0, 8'd0, 32'h5000_0000, 1, 1, 1, 0, 1};
    vt[6] = '{0, 32'h6000_0000, 9'h020, 10'd6, 8'd1,   -1, 0, 0, 0, 2, 0, 2, 8'd1, 8'd1, 32'h6000_0008, 2, 1, 0, 1, 1};
    vt[7] = '{1, 32'h0000_0000, 9'h000, 10'd0, 8'd3,   -1, 0, 0, 0, 0, 0, 0, 8'd0, 8'd0, 32'h0000_0000, 0, 0, 1, 0, 0};
    repeat (3) @(negedge clock);
    chk("reset_busy_done_error", 32'({busy, done, error}), 0);
    chk("reset_bus_ctrl", 32'({bus.request_bus, bus.begin_transaction_out, bus.data_valid_out, bus.end_transaction_out}), 0);
    chk("reset_addr_data", bus.address_data_out, 0);
    chk("reset_mem_we", 32'(mem_write_enable), 0);
    reset = 0; mem_clear = 0;
    @(negedge clock);
    for (int k = 0; k < 8; k++) run_vec(k, vt[k]);

    // Park a write burst in WRITE_DATA with the bus stalled, then reset it
    mem_clear = 1;
    @(negedge clock);
    mem_clear = 0;
    to_bus = 1; bus_start_address = 32'h7000_0000; mem_start_address = 9'h040;
    block_size = 10'd4; burst_size = 8'd3; bus.busy_in = 1; start = 1;
    @(negedge clock);
    start = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      bus.bus_grant = bus.request_bus;
      @(negedge clock);
      seen = bus.data_valid_out;
    end
    chk("wdata_reached", 32'(seen), 1);
    chk("wdata_word0", bus.address_data_out, 32'hA000_0040);
    start = 1; block_size = 0; to_bus = 0; bus_start_address = 32'h0;
    @(negedge clock);
    start = 0;
    chk("busy_start_ignored_busy", 32'(busy), 1);
    chk("busy_start_ignored_valid", 32'(bus.data_valid_out), 1);
    chk("busy_start_ignored_word", bus.address_data_out, 32'hA000_0040);
    reset = 1; start = 1; bus.error_in = 1;
    @(negedge clock);
    chk("midburst_reset_flags", 32'({busy, done, error, bus.request_bus}), 0);
    chk("midburst_reset_bus", 32'({bus.begin_transaction_out, bus.read_n_write_out, bus.data_valid_out, bus.end_transaction_out, bus.burst_size_out}), 0);
    chk("midburst_reset_addr_data", bus.address_data_out, 0);
    chk("midburst_reset_mem", 32'({mem_write_enable, mem_address}), 0);
    chk("midburst_reset_mem_wdata", mem_write_data, 0);
    reset = 0; start = 0; bus.error_in = 0; bus.busy_in = 0; bus.bus_grant = 0;
    @(negedge clock);
    chk("post_reset_idle", 32'({busy, bus.request_bus}), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_burst_master.md
DMA_BURST_MASTER -- requirements
Module: dma_burst_master

Interface
REQ-001 SHALL have parameter: ADDR_STEP, 4, bus byte-address increment per word.
REQ-002 SHALL have port: clock  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: start in 1 one-cycle transfer launch; to_bus in 1 (1: mem->bus write, 0: bus->mem read).
REQ-005 SHALL have ports: bus_start_address in 32; mem_start_address in 9; block_size in 10 (words); burst_size in 8 (max burst length minus 1).
REQ-006 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); error out 1 (sticky).
REQ-007 SHALL have ports: request_bus out 1; bus_grant in 1.
REQ-008 SHALL have ports: begin_transaction_out out 1; address_data_out out 32; burst_size_out out 8; read_n_write_out out 1; data_valid_out out 1; end_transaction_out out 1.
REQ-009 SHALL have ports: address_data_in in 32; data_valid_in in 1; end_transaction_in in 1; busy_in in 1; error_in in 1.
REQ-010 SHALL have ports: mem_address out 9; mem_write_enable out 1; mem_write_data out 32; mem_read_data in 32 (read data valid one cycle after mem_address).

Function
REQ-011 SHALL implement states IDLE, REQUEST, BEGIN, READ_DATA, WRITE_FETCH, WRITE_DATA, WRITE_END, NEXT.
REQ-012 IDLE: start=1 latches all config inputs; block_size=0 -> done pulse next cycle, no bus activity; else -> REQUEST.
REQ-013 start while busy=1 SHALL be ignored; config inputs sampled only at accepted start.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 REQUEST: request_bus=1; bus_grant=1 -> BEGIN next cycle.
REQ-016 request_bus SHALL stay 1 from REQUEST through end of the current burst, and SHALL be 0 in NEXT (one-cycle release for re-arbitration).
REQ-017 Burst length L = min(burst_size+1, remaining words); burst_size_out = L-1.
REQ-018 BEGIN (one cycle): begin_transaction_out=1, address_data_out=current bus address, read_n_write_out=!to_bus; -> READ_DATA if reading, WRITE_FETCH if writing.
REQ-019 READ_DATA: each cycle data_valid_in=1 writes address_data_in to mem at current mem address (mem_write_enable=1 same cycle), increments mem address and decrements remaining.
REQ-020 READ_DATA: end_transaction_in=1 -> NEXT; words beyond L in the burst SHALL be discarded.
REQ-021 WRITE_FETCH: one cycle driving mem_address for first word; -> WRITE_DATA.
REQ-022 WRITE_DATA: data_valid_out=1 with address_data_out=word; word accepted on cycle where busy_in=0; while busy_in=1 outputs held stable; next word presented cycle after acceptance (prefetch so no gap).
REQ-023 After L-th word accepted -> WRITE_END: end_transaction_out=1 one cycle; -> NEXT.
REQ-024 NEXT: remaining>0 -> REQUEST with bus address += L*ADDR_STEP; remaining=0 -> done=1 one cycle, -> IDLE.
REQ-025 Mem address SHALL wrap modulo 512; bus address wraps modulo 2^32.
REQ-026 error_in=1 in any state except IDLE: request_bus, data_valid_out, end_transaction_out -> 0 next cycle, error=1, -> IDLE, no done pulse.
REQ-027 error SHALL clear on next accepted start.
REQ-028 All bus outputs other than request_bus SHALL be 0 when not in the listed driving states.

Reset
REQ-029 reset=1 at any clock edge, including mid-burst, SHALL force IDLE and all outputs to 0 (busy, done, error, request_bus, all bus and mem outputs) next cycle, overriding start and error_in.

Verification
REQ-030 Read: block_size=4, burst_size=1, mem_start=0x1FF, grant immediate -> two bursts (addr A, A+8), burst_size_out=1, mem writes 0x1FF,0x000,0x001,0x002, done once.
REQ-031 Write: block_size=3, burst_size=7, busy_in high 2 cycles on word 2 -> single burst, burst_size_out=2, word 2 held stable, end_transaction_out after word 3, done.
REQ-032 block_size=0, start -> done pulse next cycle, request_bus never 1.
REQ-033 error_in during second of three bursts -> error=1, request_bus=0 next cycle, no done, then new start clears error.
REQ-034 reset asserted during WRITE_DATA -> all outputs 0 next cycle; start while busy ignored (no config change observed).
